// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I access-size encodings,
// the load result-source code and the request FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_DONE
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load lane selection/extension and the misaligned/illegal-access flag.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        we,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = read_data[{offset, 3'b000} +: 8];
    assign half_lane = read_data[{offset[1], 4'b0000} +: 16];

    // Decode access size: enables, replicated store data, extended load, fault
    always_comb begin
        byte_en    = 4'b1111;
        lane_wdata = store_data;
        load_data  = read_data;
        fault      = 1'b0;
        case (funct3)
            F3_B: begin
                if (we) byte_en = 4'b0001 << offset;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = {{24{byte_lane[7]}}, byte_lane};
            end
            F3_H: begin
                if (we) byte_en = 4'b0011 << offset;
                lane_wdata = {2{store_data[15:0]}};
                load_data  = {{16{half_lane[15]}}, half_lane};
                fault      = offset[0];
            end
            F3_W: begin
                fault = |offset;
            end
            F3_BU: begin
                load_data = {24'd0, byte_lane};
                fault     = we;
            end
            F3_HU: begin
                load_data = {16'd0, half_lane};
                fault     = we | offset[0];
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns each decoded load or store into one req/ready
// memory transaction, stalls upstream while it is outstanding and returns
// formatted load data for writeback.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iValid,
    input  logic                  iMemWrite,
    input  logic [2:0]            iResultSrc,
    input  logic [2:0]            iFunct3,
    input  logic [ADDR_WIDTH-1:0] iAddr,
    input  logic [DATA_WIDTH-1:0] iWriteData,
    output logic                  oStall,
    output logic [DATA_WIDTH-1:0] oLoadData,
    output logic                  oLoadValid,
    output logic                  oFault,
    output logic                  oMemReq,
    output logic                  oMemWe,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0] oMemWData,
    output logic [3:0]            oMemByteEn,
    input  logic                  iMemReady,
    input  logic [DATA_WIDTH-1:0] iMemRData
);

    lsu_state_e state, next_state;

    logic                  access;
    logic                  accept;
    logic                  reject;

    logic [2:0]            align_funct3;
    logic [1:0]            align_offset;
    logic                  align_we;
    logic [3:0]            align_byte_en;
    logic [DATA_WIDTH-1:0] align_wdata;
    logic [DATA_WIDTH-1:0] align_load;
    logic                  align_fault;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_byte_en;
    logic                  mem_we;
    logic [2:0]            acc_funct3;
    logic [1:0]            acc_offset;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  fault_pulse;

    // A store takes priority over a load when both are decoded.
    assign access = iValid & (iMemWrite | (iResultSrc == RESULT_SRC_LOAD));
    assign accept = (state == LSU_IDLE) & access & ~align_fault;
    assign reject = (state == LSU_IDLE) & access &  align_fault;

    // The aligner sees live inputs while idle (fault check and lane setup)
    // and the latched access afterwards (load formatting on completion).
    assign align_funct3 = (state == LSU_IDLE) ? iFunct3    : acc_funct3;
    assign align_offset = (state == LSU_IDLE) ? iAddr[1:0] : acc_offset;
    assign align_we     = (state == LSU_IDLE) ? iMemWrite  : mem_we;

    lsu_align u_align (
        .funct3     (align_funct3),
        .offset     (align_offset),
        .we         (align_we),
        .store_data (iWriteData),
        .read_data  (iMemRData),
        .byte_en    (align_byte_en),
        .lane_wdata (align_wdata),
        .load_data  (align_load),
        .fault      (align_fault)
    );

    // State register
    always_ff @(posedge iClk) begin
        if (!iRstN) state <= LSU_IDLE;
        else        state <= next_state;
    end

    // Next-state: accept -> request until ready -> one completion cycle
    always_comb begin
        next_state = state;
        case (state)
            LSU_IDLE: if (accept)    next_state = LSU_REQ;
            LSU_REQ:  if (iMemReady) next_state = LSU_DONE;
            LSU_DONE:                next_state = LSU_IDLE;
            default:                 next_state = LSU_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        oStall     = accept | (state == LSU_REQ);
        oMemReq    = (state == LSU_REQ);
        oLoadValid = (state == LSU_DONE) & ~mem_we;
    end

    // Latch the accepted access, capture load data, register the fault pulse
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= '0;
            mem_we      <= 1'b0;
            acc_funct3  <= '0;
            acc_offset  <= '0;
            load_data   <= '0;
            fault_pulse <= 1'b0;
        end else begin
            fault_pulse <= reject;
            if (accept) begin
                mem_addr    <= {iAddr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata   <= align_wdata;
                mem_byte_en <= align_byte_en;
                mem_we      <= iMemWrite;
                acc_funct3  <= iFunct3;
                acc_offset  <= iAddr[1:0];
            end
            if ((state == LSU_REQ) && iMemReady && !mem_we) begin
                load_data <= align_load;
            end
        end
    end

    assign oMemAddr   = mem_addr;
    assign oMemWData  = mem_wdata;
    assign oMemByteEn = mem_byte_en;
    assign oMemWe     = mem_we;
    assign oLoadData  = load_data;
    assign oFault     = fault_pulse;

endmodule
